sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the processor top level.
- Replaces the single-nibble static display; shows the full ALU or register value across DIGITS digits.
- Adds a load-strobed shadow register, leading-zero blanking, per-digit decimal points and a one-cycle anode blanking gap on every digit switch (anti-ghosting).
- Sits beside the datapath. The datapath drives `value`/`load`; the outputs go straight to board pins.

Parameters:
- DIGITS, 4: number of digits scanned; the value width is 4*DIGITS bits. Legal range 1..8.
- REFRESH_DIV, 50000: clocks per digit slot, including the blank cycle. Must be >= 2.
- ANODE_ACTIVE_LOW, 1: 1 = anode enable driven as 0; 0 = anode enable driven as 1.
- SEG_ACTIVE_LOW, 1: 1 = a lit segment or dp is driven as 0; 0 = it is driven as 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- value  in  4*DIGITS  hex value to display; nibble i drives digit i, and digit 0 is the rightmost
- load  in  1  capture `value` into the shadow register on this clock edge
- blank_lz  in  1  enable leading-zero blanking
- dp  in  DIGITS  decimal-point request per digit; captured with `load`
- sseg_cathode  out  7  segments {g,f,e,d,c,b,a}
- sseg_dp  out  1  decimal-point segment
- sseg_anode  out  DIGITS  digit enables
- digit_idx  out  clog2(DIGITS) (min 1)  index of the digit currently driven, for debug and test

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, idx=0, shadow value=0, shadow dp=0.
  - sseg_anode = all inactive; sseg_cathode and sseg_dp = all segments off (inactive level); digit_idx=0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - A tick occurs when cnt==REFRESH_DIV-1; on a tick, cnt returns to 0.
- Digit index:
  - On a tick, idx increments; it wraps from DIGITS-1 to 0.
  - With DIGITS=1, idx stays 0.
- Shadow register:
  - On an edge with load=1, shadow value <= value and shadow dp <= dp.
  - With load=0, the shadow holds.
- Output registers, loaded on every edge from the pre-edge cnt, idx and shadow, so outputs lag the internal state by exactly one clock:
  - If cnt==0: anodes all inactive and segments off. This is the blank gap.
  - Otherwise:
    - anode[idx] active, all other anodes inactive.
    - cathode = hex decode of shadow nibble idx.
    - sseg_dp = shadow dp[idx].
    - digit_idx = idx.
- Result per slot: each digit is lit for REFRESH_DIV-1 clocks and dark for 1 clock.
- Leading-zero blanking: with blank_lz=1, digit i (i>0) shows segments off and dp off when shadow nibbles DIGITS-1..i are all zero. Digit 0 is never blanked. blank_lz is sampled live, not shadowed.
- Simultaneous load and tick: the shadow updates on that edge. Output registers on that same edge use the old shadow; the next lit slot shows the new value.
- Encoding: patterns are stored active-high ({g..a}, 1 = lit) and inverted at the output register when SEG_ACTIVE_LOW=1. Active-low values:
  - 0 = 1000000, 1 = 1111001, 8 = 0000000
  - A = 0001000, F = 0001110
  - all off = 1111111
- Reset asserted mid-scan forces all outputs to their reset levels immediately (asynchronously). After release, scanning restarts at digit 0 with a blank cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package (sseg_pkg):
  - the 16 active-high hex segment patterns
  - the SEG_OFF constant
  - the function computing the digit_idx width
- Sub-module hex7_decode: purely combinational, 4-bit nibble in, 7-bit active-high pattern out. One instance, fed by the muxed nibble.
- Everything else (prescaler, index counter, shadow register, blanking logic, output registers) lives in sseg_scan_driver.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4 and active-low outputs.
1. Reset, then load value=0x12AF at the first edge after release:
   - Across digits 0..3, cathode sequence is F=0001110, A=0001000, 2=0100100, 1=1111001.
   - Anode is 1110 then 1101, 1011, 0111; each is low for 3 clocks and separated by one 1111 clock.
2. Wrap-around: run 20 digit slots and check digit_idx sequence 0,1,2,3,0,...
   - Check that anode never has two bits low in any cycle.
3. Leading-zero blanking: blank_lz=1, value=0x0030.
   - Digits 3 and 2 show 1111111 with dp off; digit 1 shows 3=0110000; digit 0 shows 0=1000000.
   - With value=0x0000, only digit 0 is lit.
4. Load coincident with tick: value 0x1111 displayed, then load 0x8888 on the edge where cnt==3.
   - The following blank cycle shows no segments.
   - The next lit slot shows 8=0000000.
   - No partially updated slot appears.
5. Mid-scan reset: assert reset during digit 2, between clock edges.
   - Anode=1111 and cathode=1111111 immediately.
   - After release, one blank cycle, then digit 0 shows 0=1000000 (shadow cleared).
6. dp: load dp=0101 with value 0x0000.
   - sseg_dp=0 only during digit 0 and digit 2 lit cycles.
   - sseg_dp=1 in all blank cycles.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high hex glyphs,
// the all-off pattern and the digit-index width helper.
package sseg_pkg;

    // Patterns are {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    // A single-digit display still needs a 1-bit index port.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex7_decode.sv
// Nibble to active-high seven-segment glyph; purely combinational, no state,
// no flow control.
module hex7_decode
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver with load-strobed shadow, leading-zero blanking
// and a one-clock dark gap per digit; all outputs registered (1-clock lag), no backpressure.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4*DIGITS-1:0]          value,
    input  logic                         load,
    input  logic                         blank_lz,
    input  logic [DIGITS-1:0]            dp,
    output logic [6:0]                   sseg_cathode,
    output logic                         sseg_dp,
    output logic [DIGITS-1:0]            sseg_anode,
    output logic [idx_width(DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]        CAT_OFF   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic              DP_OFF    = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [DIGITS-1:0]   r_anode;
    logic [6:0]          r_cathode;
    logic                r_dp;
    logic [IDX_W-1:0]    r_digit_idx;

    logic                w_tick;
    logic [3:0]          w_nibs [DIGITS];
    logic [DIGITS-1:0]   w_zero_from;
    logic                w_lz_blank;
    logic [6:0]          w_pat;
    logic [6:0]          w_seg_on;
    logic                w_dp_on;
    logic [DIGITS-1:0]   w_onehot;

    assign w_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else if (load) begin
            r_shadow    <= value;
            r_shadow_dp <= dp;
        end
    end

    // w_zero_from[i] is set when every nibble from the top digit down to i is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_nibs[i] = r_shadow[4*i +: 4];
        end
        w_zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero       = all_zero & (w_nibs[i] == 4'h0);
            w_zero_from[i] = all_zero;
        end
    end

    hex7_decode u_hex7_decode (
        .i_nibble (w_nibs[r_idx]),
        .o_seg    (w_pat)
    );

    assign w_lz_blank = blank_lz && (r_idx != '0) && w_zero_from[r_idx];
    assign w_seg_on   = w_lz_blank ? SEG_OFF : w_pat;
    assign w_dp_on    = !w_lz_blank && r_shadow_dp[r_idx];
    assign w_onehot   = DIGITS'(1) << r_idx;

    // Output stage samples pre-edge state, so a load coincident with a tick only shows next slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_anode     <= ANODE_OFF;
            r_cathode   <= CAT_OFF;
            r_dp        <= DP_OFF;
            r_digit_idx <= '0;
        end else begin
            r_digit_idx <= r_idx;
            if (r_cnt == '0) begin
                r_anode   <= ANODE_OFF;
                r_cathode <= CAT_OFF;
                r_dp      <= DP_OFF;
            end else begin
                r_anode   <= ANODE_ACTIVE_LOW ? ~w_onehot : w_onehot;
                r_cathode <= SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
                r_dp      <= SEG_ACTIVE_LOW ? ~w_dp_on : w_dp_on;
            end
        end
    end

    assign sseg_anode   = r_anode;
    assign sseg_cathode = r_cathode;
    assign sseg_dp      = r_dp;
    assign digit_idx    = r_digit_idx;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with DIGITS=4, REFRESH_DIV=4, active-low pins.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp;
    logic [6:0]  sseg_cathode;
    logic        sseg_dp;
    logic [3:0]  sseg_anode;
    logic [1:0]  digit_idx;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [6:0] OFF = 7'b1111111;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(4), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz), .dp(dp),
        .sseg_cathode(sseg_cathode), .sseg_dp(sseg_dp), .sseg_anode(sseg_anode),
        .digit_idx(digit_idx)
    );

    // Leaves the bench at the negedge right after the first edge out of reset (a blank cycle).
    task automatic reset_and_load(input logic [15:0] v, input logic [3:0] d);
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        value = v;
        dp    = d;
        load  = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; blank_lz = 1'b0; value = 16'hFFFF; dp = 4'hF;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL reset_anode: got %b want 1111", sseg_anode); end
        compared++; if (sseg_cathode !== OFF) begin mismatched++; $display("FAIL reset_cathode: got %b want %b", sseg_cathode, OFF); end
        compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL reset_dp: got %b want 1", sseg_dp); end
        compared++; if (digit_idx !== 2'd0) begin mismatched++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
        @(negedge clk); value = 16'h8888; load = 1'b1;
        @(negedge clk); load = 1'b0;
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL reset_hold_anode: got %b want 1111", sseg_anode); end
        reset = 1'b1;
        @(negedge clk);
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL reset_gap_anode: got %b want 1111", sseg_anode); end
        compared++; if (sseg_cathode !== OFF) begin mismatched++; $display("FAIL reset_gap_cathode: got %b want %b", sseg_cathode, OFF); end
        @(negedge clk);
        compared++; if (sseg_anode !== 4'b1110) begin mismatched++; $display("FAIL reset_first_anode: got %b want 1110", sseg_anode); end
        compared++; if (sseg_cathode !== 7'b1000000) begin mismatched++; $display("FAIL reset_shadow_clear: got %b want 1000000", sseg_cathode); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_cat [4];
        logic [3:0] exp_an;
        exp_cat = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        reset_and_load(16'h12AF, 4'b0000);
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL scan_first_gap: got %b want 1111", sseg_anode); end
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (sseg_anode !== exp_an) begin mismatched++; $display("FAIL scan_anode d=%0d k=%0d: got %b want %b", d, k, sseg_anode, exp_an); end
                compared++; if (sseg_cathode !== exp_cat[d]) begin mismatched++; $display("FAIL scan_cathode d=%0d k=%0d: got %b want %b", d, k, sseg_cathode, exp_cat[d]); end
                compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL scan_dp d=%0d: got %b want 1", d, sseg_dp); end
                compared++; if (digit_idx !== 2'(d)) begin mismatched++; $display("FAIL scan_idx d=%0d: got %0d want %0d", d, digit_idx, d); end
            end
            @(negedge clk);
            compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL scan_gap_anode d=%0d: got %b want 1111", d, sseg_anode); end
            compared++; if (sseg_cathode !== OFF) begin mismatched++; $display("FAIL scan_gap_cathode d=%0d: got %b want %b", d, sseg_cathode, OFF); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_an;
        reset_and_load(16'h12AF, 4'b0000);
        for (int s = 0; s < 20; s++) begin
            exp_an = ~(4'b0001 << (s % 4));
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (digit_idx !== 2'(s % 4)) begin mismatched++; $display("FAIL wrap_idx slot=%0d: got %0d want %0d", s, digit_idx, s % 4); end
                compared++; if (sseg_anode !== exp_an) begin mismatched++; $display("FAIL wrap_anode slot=%0d: got %b want %b", s, sseg_anode, exp_an); end
                compared++; if ($countones(~sseg_anode) > 1) begin mismatched++; $display("FAIL wrap_multi_low slot=%0d: got %b want at most one low", s, sseg_anode); end
            end
            @(negedge clk);
            compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL wrap_gap slot=%0d: got %b want 1111", s, sseg_anode); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_cat [4];
        logic [3:0] exp_an;
        blank_lz = 1'b1;
        exp_cat = '{7'b1000000, 7'b0110000, OFF, OFF};
        reset_and_load(16'h0030, 4'b1100);
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (sseg_anode !== exp_an) begin mismatched++; $display("FAIL lz_anode d=%0d: got %b want %b", d, sseg_anode, exp_an); end
                compared++; if (sseg_cathode !== exp_cat[d]) begin mismatched++; $display("FAIL lz_cathode d=%0d: got %b want %b", d, sseg_cathode, exp_cat[d]); end
                compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL lz_dp d=%0d: got %b want 1", d, sseg_dp); end
            end
            @(negedge clk);
        end
        exp_cat = '{7'b1000000, OFF, OFF, OFF};
        reset_and_load(16'h0000, 4'b0000);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (sseg_cathode !== exp_cat[d]) begin mismatched++; $display("FAIL lz_zero_cathode d=%0d: got %b want %b", d, sseg_cathode, exp_cat[d]); end
            end
            @(negedge clk);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_load_tick();
        logic [3:0] exp_an;
        reset_and_load(16'h1111, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        compared++; if (sseg_cathode !== 7'b1111001) begin mismatched++; $display("FAIL lt_before: got %b want 1111001", sseg_cathode); end
        value = 16'h8888; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        compared++; if (sseg_cathode !== 7'b1111001) begin mismatched++; $display("FAIL lt_tick_edge_old: got %b want 1111001", sseg_cathode); end
        compared++; if (sseg_anode !== 4'b1110) begin mismatched++; $display("FAIL lt_tick_edge_anode: got %b want 1110", sseg_anode); end
        @(negedge clk);
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL lt_gap_anode: got %b want 1111", sseg_anode); end
        compared++; if (sseg_cathode !== OFF) begin mismatched++; $display("FAIL lt_gap_cathode: got %b want %b", sseg_cathode, OFF); end
        compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL lt_gap_dp: got %b want 1", sseg_dp); end
        for (int d = 1; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (sseg_cathode !== 7'b0000000) begin mismatched++; $display("FAIL lt_new d=%0d k=%0d: got %b want 0000000", d, k, sseg_cathode); end
                compared++; if (sseg_anode !== exp_an) begin mismatched++; $display("FAIL lt_anode d=%0d: got %b want %b", d, sseg_anode, exp_an); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midreset();
        reset_and_load(16'h12AF, 4'b0000);
        repeat (9) @(negedge clk);
        compared++; if (sseg_anode !== 4'b1011) begin mismatched++; $display("FAIL mr_in_digit2: got %b want 1011", sseg_anode); end
        #2 reset = 1'b0;
        #1;
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL mr_anode: got %b want 1111", sseg_anode); end
        compared++; if (sseg_cathode !== OFF) begin mismatched++; $display("FAIL mr_cathode: got %b want %b", sseg_cathode, OFF); end
        compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL mr_dp: got %b want 1", sseg_dp); end
        compared++; if (digit_idx !== 2'd0) begin mismatched++; $display("FAIL mr_idx: got %0d want 0", digit_idx); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++; if (sseg_anode !== 4'b1111) begin mismatched++; $display("FAIL mr_gap: got %b want 1111", sseg_anode); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compared++; if (sseg_anode !== 4'b1110) begin mismatched++; $display("FAIL mr_restart_anode k=%0d: got %b want 1110", k, sseg_anode); end
            compared++; if (sseg_cathode !== 7'b1000000) begin mismatched++; $display("FAIL mr_restart_cathode k=%0d: got %b want 1000000", k, sseg_cathode); end
            compared++; if (digit_idx !== 2'd0) begin mismatched++; $display("FAIL mr_restart_idx k=%0d: got %0d want 0", k, digit_idx); end
        end
    endtask

    task automatic test_dp();
        logic exp_dp;
        reset_and_load(16'h0000, 4'b0101);
        compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL dp_first_gap: got %b want 1", sseg_dp); end
        for (int d = 0; d < 4; d++) begin
            exp_dp = (d == 0 || d == 2) ? 1'b0 : 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                compared++; if (sseg_dp !== exp_dp) begin mismatched++; $display("FAIL dp_lit d=%0d k=%0d: got %b want %b", d, k, sseg_dp, exp_dp); end
                compared++; if (sseg_cathode !== 7'b1000000) begin mismatched++; $display("FAIL dp_cathode d=%0d: got %b want 1000000", d, sseg_cathode); end
            end
            @(negedge clk);
            compared++; if (sseg_dp !== 1'b1) begin mismatched++; $display("FAIL dp_gap d=%0d: got %b want 1", d, sseg_dp); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        value    = 16'h0000;
        dp       = 4'h0;
        test_reset();
        test_scan();
        test_wrap();
        test_lz();
        test_load_tick();
        test_midreset();
        test_dp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
